// File: rtl/ham_dec_arbiter_pkg.sv
//------------------------------------------------------------------------------
// ham_dec_arbiter_pkg : shared FSM state type and Hamming(7,4) widths
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ham_dec_arbiter_pkg;

  localparam int CODE_W = 7;
  localparam int DATA_W = 4;
  localparam int SYN_W  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ham_decoder.sv
//------------------------------------------------------------------------------
// ham_decoder : combinational Hamming(7,4) syndrome and single-bit correction
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ham_decoder
  import ham_dec_arbiter_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  output logic [SYN_W-1:0]  o_syn,
  output logic [DATA_W-1:0] o_data
);

  logic [CODE_W-1:0] w_fixed;

  assign o_syn = {i_code[3] ^ i_code[4] ^ i_code[5] ^ i_code[6],
                  i_code[1] ^ i_code[2] ^ i_code[5] ^ i_code[6],
                  i_code[0] ^ i_code[2] ^ i_code[4] ^ i_code[6]};

  // Syndrome is the 1-based position of the flipped bit; zero leaves the word as is.
  always_comb begin
    w_fixed = i_code;
    for (int i = 0; i < CODE_W; i++) begin
      w_fixed[i] = i_code[i] ^ (o_syn == SYN_W'(i + 1));
    end
  end

  assign o_data = {w_fixed[6], w_fixed[5], w_fixed[4], w_fixed[2]};

endmodule

`default_nettype wire

// File: rtl/ham_dec_arbiter.sv
//------------------------------------------------------------------------------
// ham_dec_arbiter : two-requester round-robin front end for a Hamming(7,4) decoder
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ham_dec_arbiter
  import ham_dec_arbiter_pkg::*;
#(
  parameter int CNT_W = 8
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  input  logic [6:0]        req_code0,
  input  logic [6:0]        req_code1,
  output logic [1:0]        req_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_data,
  output logic [2:0]        out_syn,
  output logic              out_src,
  output logic              out_err,
  output logic [CNT_W-1:0]  err_cnt,
  input  logic              cnt_clr
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_grant;
  logic [CODE_W-1:0]   r_code;
  logic                r_src;
  logic [DATA_W-1:0]   r_out_data;
  logic [SYN_W-1:0]    r_out_syn;
  logic                r_out_src;
  logic                r_out_err;
  logic [CNT_W-1:0]    r_err_cnt;

  logic                w_grant;
  logic                w_grant_idx;
  logic [1:0]          w_req_ready;
  logic [CODE_W-1:0]   w_sel_code;
  logic [SYN_W-1:0]    w_syn;
  logic [DATA_W-1:0]   w_data;

  // A tie goes to whoever did not win last; a lone request always wins.
  assign w_grant_idx = (&req_valid) ? ~r_last_grant : req_valid[1];
  assign w_sel_code  = w_grant_idx ? req_code1 : req_code0;

  ham_decoder u_dec (
    .i_code (r_code),
    .o_syn  (w_syn),
    .o_data (w_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 2'b00;
    w_grant     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (|req_valid) begin
          w_grant     = 1'b1;
          w_req_ready = w_grant_idx ? 2'b10 : 2'b01;
          w_state_nxt = DECODE;
        end
      end
      DECODE: w_state_nxt = HOLD;
      HOLD: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_code       <= '0;
      r_src        <= 1'b0;
      r_out_data   <= '0;
      r_out_syn    <= '0;
      r_out_src    <= 1'b0;
      r_out_err    <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      if (w_grant) begin
        r_code       <= w_sel_code;
        r_src        <= w_grant_idx;
        r_last_grant <= w_grant_idx;
      end
      if (r_state == DECODE) begin
        r_out_data <= w_data;
        r_out_syn  <= w_syn;
        r_out_src  <= r_src;
        r_out_err  <= |w_syn;
      end
      // Clear has priority over a same-cycle increment; the count sticks at all-ones.
      if (cnt_clr) begin
        r_err_cnt <= '0;
      end else if ((r_state == DECODE) && (|w_syn) && (r_err_cnt != {CNT_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign req_ready = w_req_ready;
  assign out_valid = (r_state == HOLD);
  assign out_data  = r_out_data;
  assign out_syn   = r_out_syn;
  assign out_src   = r_out_src;
  assign out_err   = r_out_err;
  assign err_cnt   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ham_dec_arbiter.sv
//------------------------------------------------------------------------------
// tb_ham_dec_arbiter : directed and random checks against a transaction-level model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ham_dec_arbiter;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [6:0]       req_code0;
  logic [6:0]       req_code1;
  logic [1:0]       req_ready;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_data;
  logic [2:0]       out_syn;
  logic             out_src;
  logic             out_err;
  logic [CNT_W-1:0] err_cnt;
  logic             cnt_clr;

  ham_dec_arbiter #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_code0 (req_code0),
    .req_code1 (req_code1),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_syn   (out_syn),
    .out_src   (out_src),
    .out_err   (out_err),
    .err_cnt   (err_cnt),
    .cnt_clr   (cnt_clr)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Model: one outstanding transaction, visible from its ready cycle until accepted.
  int         cyc       = 0;
  bit         m_pend    = 1'b0;
  int         m_rdy_cyc = 0;
  bit         m_last    = 1'b1;
  logic [3:0] m_data    = '0;
  logic [2:0] m_syn     = '0;
  bit         m_src     = 1'b0;
  int         m_cnt     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Hamming property: the syndrome is the XOR of the 1-based positions of all set bits.
  function automatic logic [2:0] ref_syn(input logic [6:0] c);
    int s;
    s = 0;
    for (int i = 0; i < 7; i++) if (c[i]) s = s ^ (i + 1);
    return 3'(s);
  endfunction

  function automatic logic [3:0] ref_data(input logic [6:0] c);
    logic [6:0] x;
    int         s;
    x = c;
    s = int'(ref_syn(c));
    if (s != 0) x[s-1] = ~x[s-1];
    return {x[6], x[5], x[4], x[2]};
  endfunction

  task automatic model_reset();
    m_pend = 1'b0;
    m_last = 1'b1;
    m_data = '0;
    m_syn  = '0;
    m_src  = 1'b0;
    m_cnt  = 0;
  endtask

  // Called at posedge+1: drive one cycle, check against the model, advance over the edge.
  task automatic tick(input logic [1:0] rv, input logic [6:0] c0, input logic [6:0] c1,
                      input logic ordy, input logic clr, output int gnt);
    logic [1:0] exp_rr;
    bit         exp_ov;
    bit         g;
    logic [6:0] code;
    req_valid = rv;
    req_code0 = c0;
    req_code1 = c1;
    out_ready = ordy;
    cnt_clr   = clr;
    #1;
    g      = (rv == 2'b11) ? ~m_last : rv[1];
    exp_rr = (!m_pend && rv != 2'b00) ? (g ? 2'b10 : 2'b01) : 2'b00;
    exp_ov = m_pend && (cyc >= m_rdy_cyc);
    chk("req_ready", req_ready, exp_rr);
    chk("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      chk("out_data", out_data, m_data);
      chk("out_syn",  out_syn,  m_syn);
      chk("out_src",  out_src,  m_src);
      chk("out_err",  out_err,  m_syn != 3'd0);
    end
    chk("err_cnt", err_cnt, m_cnt);
    gnt = -1;
    @(posedge clk);
    if (m_pend && cyc == m_rdy_cyc - 1 && m_syn != 3'd0 && m_cnt < CNT_MAX) m_cnt++;
    if (clr) m_cnt = 0;
    if (exp_ov && ordy) begin
      m_pend = 1'b0;
    end else if (!m_pend && rv != 2'b00) begin
      code      = g ? c1 : c0;
      m_pend    = 1'b1;
      m_rdy_cyc = cyc + 2;
      m_data    = ref_data(code);
      m_syn     = ref_syn(code);
      m_src     = g;
      m_last    = g;
      gnt       = int'(g);
    end
    cyc++;
    #1;
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    req_valid = '0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cyc++;
  endtask

  // One complete transaction from a single requester with out_ready held high.
  task automatic send_one(input bit src, input logic [6:0] code);
    int g;
    tick(src ? 2'b10 : 2'b01, code, code, 1'b1, 1'b0, g);
    tick(2'b00, '0, '0, 1'b1, 1'b0, g);
    tick(2'b00, '0, '0, 1'b1, 1'b0, g);
  endtask

  initial begin
    int g;
    int k;
    logic [6:0] good;
    logic [6:0] bad;
    good      = 7'b1010101;
    bad       = 7'b1000101;
    rst       = 1'b1;
    req_valid = '0;
    req_code0 = '0;
    req_code1 = '0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data",  out_data,  4'h0);
    chk("rst_out_syn",   out_syn,   3'h0);
    chk("rst_err_cnt",   err_cnt,   '0);
    chk("rst_req_ready", req_ready, 2'b00);
    apply_reset();

    // Tie from reset: grants alternate starting with requester 0.
    k = 0;
    for (int i = 0; i < 12; i++) begin
      tick(2'b11, good, good, 1'b1, 1'b0, g);
      if (g >= 0) begin
        if (k < 4) chk("tie_grant", g, k % 2);
        k++;
      end
    end
    chk("tie_grants_seen", k, 4);
    apply_reset();

    // Clean word from requester 0 with two-cycle latency.
    tick(2'b01, good, '0, 1'b1, 1'b0, g);
    tick(2'b00, '0, '0, 1'b1, 1'b0, g);
    chk("clean_valid", out_valid, 1'b1);
    chk("clean_data",  out_data,  4'b1011);
    chk("clean_syn",   out_syn,   3'd0);
    chk("clean_err",   out_err,   1'b0);
    chk("clean_src",   out_src,   1'b0);
    tick(2'b00, '0, '0, 1'b1, 1'b0, g);
    chk("clean_cnt", err_cnt, 0);

    // Single-bit error from requester 1.
    tick(2'b10, '0, bad, 1'b1, 1'b0, g);
    tick(2'b00, '0, '0, 1'b1, 1'b0, g);
    chk("err_data", out_data, 4'b1011);
    chk("err_syn",  out_syn,  3'd5);
    chk("err_err",  out_err,  1'b1);
    chk("err_src",  out_src,  1'b1);
    chk("err_cnt1", err_cnt,  1);
    tick(2'b00, '0, '0, 1'b1, 1'b0, g);

    // Backpressure: five stalled HOLD cycles while both requesters keep asking.
    tick(2'b01, 7'b0110011, '0, 1'b0, 1'b0, g);
    tick(2'b11, 7'b0000000, bad, 1'b0, 1'b0, g);
    for (int i = 0; i < 5; i++) begin
      tick(2'b11, 7'b0000000, bad, 1'b0, 1'b0, g);
      chk("bp_hold_valid", out_valid, 1'b1);
    end
    tick(2'b00, '0, '0, 1'b1, 1'b0, g);
    chk("bp_released", out_valid, 1'b0);

    // Saturation with a 2-bit counter, then clear colliding with an increment.
    apply_reset();
    for (int i = 1; i <= 5; i++) begin
      send_one(i[0], bad);
      chk("sat_cnt", err_cnt, (i < 3) ? i : 3);
    end
    tick(2'b01, bad, '0, 1'b1, 1'b0, g);
    tick(2'b00, '0, '0, 1'b1, 1'b1, g);
    chk("clr_wins", err_cnt, 0);
    tick(2'b00, '0, '0, 1'b1, 1'b0, g);

    // Reset asserted while a result is held.
    tick(2'b10, '0, bad, 1'b0, 1'b0, g);
    tick(2'b00, '0, '0, 1'b0, 1'b0, g);
    chk("pre_rst_valid", out_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_hold_valid", out_valid, 1'b0);
    chk("rst_hold_cnt",   err_cnt,   0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cyc++;
    for (int i = 0; i < 3; i++) tick(2'b00, '0, '0, 1'b1, 1'b0, g);
    tick(2'b11, good, bad, 1'b1, 1'b0, g);
    chk("post_rst_grant", g, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      tick(2'($urandom_range(0, 3)), 7'($urandom), 7'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0), g);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
